lap_referee: RTL and testbench

- Race-progress controller that sequences the end of a race.
- Tracks checkpoint and lap progress for both cars from their world coordinates and keeps the race timer.
- Assigns finishing places and asserts is_game_end to the state encoder, replacing the constant-0 tie-off.
- Its place outputs feed the flag HUD as p1_flag_order / p2_flag_order.

---
 rtl/lap_referee.sv | 223 ++++++++++++++++++++++
 tb/tb_lap_referee.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_referee.sv
// Race-progress referee: checkpoint/lap tracking for two cars, race timer,
// finishing places, grace window and the sticky end-of-race flag.
module lap_referee #(
   parameter int unsigned NUM_LAPS    = 3,
   parameter int unsigned NUM_CP      = 4,
   parameter logic [39:0] CP_X        = {10'd15, 10'd160, 10'd300, 10'd160},
   parameter logic [39:0] CP_Y        = {10'd125, 10'd220, 10'd125, 10'd20},
   parameter logic [9:0]  CP_HALF     = 10'd12,
   parameter int unsigned TICK_DIV    = 1_000_000,
   parameter int unsigned GRACE_TICKS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic [9:0]  p1_x,
   input  logic [9:0]  p1_y,
   input  logic [9:0]  p2_x,
   input  logic [9:0]  p2_y,
   output logic [2:0]  p1_lap,
   output logic [2:0]  p2_lap,
   output logic [1:0]  p1_next_cp,
   output logic [1:0]  p2_next_cp,
   output logic [1:0]  p1_flag_order,
   output logic [1:0]  p2_flag_order,
   output logic [15:0] p1_time,
   output logic [15:0] p2_time,
   output logic [15:0] race_time,
   output logic [1:0]  winner,
   output logic        is_game_end
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GW = $clog2(GRACE_TICKS + 1);
   localparam logic [2:0]    ST_IDLE    = 3'd0;
   localparam logic [2:0]    ST_RACING  = 3'd4;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [GW-1:0] GRACE_END  = GW'(GRACE_TICKS);
   localparam logic [GW-1:0] GRACE_ONE  = GW'(1);
   localparam logic [2:0]    LAPS_DONE  = 3'(NUM_LAPS);
   localparam logic [1:0]    LAST_CP    = 2'(NUM_CP - 1);

   // Unsigned distance without wrap: subtract the smaller from the larger.
   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      if (a >= b) abs_diff = a - b;
      else        abs_diff = b - a;
   endfunction

   function automatic logic in_box(input logic [9:0] x, input logic [9:0] y, input logic [1:0] cp);
      logic [9:0] cx;
      logic [9:0] cy;
      case (cp)
         2'd0:    begin cx = CP_X[9:0];   cy = CP_Y[9:0];   end
         2'd1:    begin cx = CP_X[19:10]; cy = CP_Y[19:10]; end
         2'd2:    begin cx = CP_X[29:20]; cy = CP_Y[29:20]; end
         default: begin cx = CP_X[39:30]; cy = CP_Y[39:30]; end
      endcase
      in_box = (abs_diff(x, cx) <= CP_HALF) && (abs_diff(y, cy) <= CP_HALF);
   endfunction

   // Returns {lap, next_cp} after a hit on the current target.
   function automatic logic [4:0] step_cp(input logic [2:0] lap, input logic [1:0] nxt);
      if (nxt == 2'd0)          step_cp = {lap + 3'd1, 2'd1};
      else if (nxt == LAST_CP)  step_cp = {lap, 2'd0};
      else                      step_cp = {lap, nxt + 2'd1};
   endfunction

   logic [PW-1:0] presc_r, presc_s;
   logic [GW-1:0] grace_r, grace_s;
   logic [15:0]   race_time_r, race_time_s;
   logic [2:0]    lap1_r, lap1_s, lap2_r, lap2_s;
   logic [1:0]    next1_r, next1_s, next2_r, next2_s;
   logic [1:0]    place1_r, place1_s, place2_r, place2_s;
   logic [15:0]   time1_r, time1_s, time2_r, time2_s;
   logic [1:0]    winner_r, winner_s;
   logic          end_r, end_s;

   logic run_s, tick_s, fin1_s, fin2_s, hit1_s, hit2_s, done1_s, done2_s;

   assign run_s   = (state == ST_RACING) && !end_r;
   assign tick_s  = run_s && (presc_r == PRESC_MAX);
   assign fin1_s  = (place1_r != 2'd0);
   assign fin2_s  = (place2_r != 2'd0);
   assign hit1_s  = run_s && !fin1_s && in_box(p1_x, p1_y, next1_r);
   assign hit2_s  = run_s && !fin2_s && in_box(p2_x, p2_y, next2_r);
   assign done1_s = hit1_s && (next1_r == 2'd0) && ((lap1_r + 3'd1) == LAPS_DONE);
   assign done2_s = hit2_s && (next2_r == 2'd0) && ((lap2_r + 3'd1) == LAPS_DONE);

   // Next-state computation: IDLE clears, RACING advances, all else holds.
   always_comb begin
      presc_s     = presc_r;
      grace_s     = grace_r;
      race_time_s = race_time_r;
      lap1_s      = lap1_r;
      lap2_s      = lap2_r;
      next1_s     = next1_r;
      next2_s     = next2_r;
      place1_s    = place1_r;
      place2_s    = place2_r;
      time1_s     = time1_r;
      time2_s     = time2_r;
      winner_s    = winner_r;
      end_s       = end_r;
      if (state == ST_IDLE) begin
         presc_s     = {PW{1'b0}};
         grace_s     = {GW{1'b0}};
         race_time_s = 16'd0;
         lap1_s      = 3'd0;
         lap2_s      = 3'd0;
         next1_s     = 2'd1;
         next2_s     = 2'd1;
         place1_s    = 2'd0;
         place2_s    = 2'd0;
         time1_s     = 16'd0;
         time2_s     = 16'd0;
         winner_s    = 2'd0;
         end_s       = 1'b0;
      end else if (run_s) begin
         if (tick_s) begin
            presc_s = {PW{1'b0}};
            if (race_time_r != 16'hFFFF) race_time_s = race_time_r + 16'd1;
            else                         race_time_s = race_time_r;
         end else begin
            presc_s = presc_r + PRESC_ONE;
         end
         if (hit1_s) {lap1_s, next1_s} = step_cp(lap1_r, next1_r);
         else        lap1_s = lap1_r;
         if (hit2_s) {lap2_s, next2_s} = step_cp(lap2_r, next2_r);
         else        lap2_s = lap2_r;
         // Finish times capture the pre-increment race_time of this cycle.
         if (done1_s && done2_s) begin
            place1_s = 2'd1;
            place2_s = 2'd1;
            time1_s  = race_time_r;
            time2_s  = race_time_r;
            winner_s = 2'd3;
            end_s    = 1'b1;
         end else if (done1_s) begin
            time1_s = race_time_r;
            if (fin2_s) begin
               place1_s = 2'd2;
               end_s    = 1'b1;
            end else begin
               place1_s = 2'd1;
               winner_s = 2'd1;
            end
         end else if (done2_s) begin
            time2_s = race_time_r;
            if (fin1_s) begin
               place2_s = 2'd2;
               end_s    = 1'b1;
            end else begin
               place2_s = 2'd1;
               winner_s = 2'd2;
            end
         end else if (tick_s && (fin1_s != fin2_s)) begin
            grace_s = grace_r + GRACE_ONE;
            if ((grace_r + GRACE_ONE) == GRACE_END) begin
               end_s = 1'b1;
               if (!fin1_s) begin
                  place1_s = 2'd2;
                  time1_s  = 16'hFFFF;
               end else begin
                  place2_s = 2'd2;
                  time2_s  = 16'hFFFF;
               end
            end else begin
               end_s = end_r;
            end
         end else begin
            grace_s = grace_r;
         end
      end else begin
         presc_s = presc_r;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r     <= {PW{1'b0}};
         grace_r     <= {GW{1'b0}};
         race_time_r <= 16'd0;
         lap1_r      <= 3'd0;
         lap2_r      <= 3'd0;
         next1_r     <= 2'd1;
         next2_r     <= 2'd1;
         place1_r    <= 2'd0;
         place2_r    <= 2'd0;
         time1_r     <= 16'd0;
         time2_r     <= 16'd0;
         winner_r    <= 2'd0;
         end_r       <= 1'b0;
      end else begin
         presc_r     <= presc_s;
         grace_r     <= grace_s;
         race_time_r <= race_time_s;
         lap1_r      <= lap1_s;
         lap2_r      <= lap2_s;
         next1_r     <= next1_s;
         next2_r     <= next2_s;
         place1_r    <= place1_s;
         place2_r    <= place2_s;
         time1_r     <= time1_s;
         time2_r     <= time2_s;
         winner_r    <= winner_s;
         end_r       <= end_s;
      end
   end

   assign p1_lap        = lap1_r;
   assign p2_lap        = lap2_r;
   assign p1_next_cp    = next1_r;
   assign p2_next_cp    = next2_r;
   assign p1_flag_order = place1_r;
   assign p2_flag_order = place2_r;
   assign p1_time       = time1_r;
   assign p2_time       = time2_r;
   assign race_time     = race_time_r;
   assign winner        = winner_r;
   assign is_game_end   = end_r;

endmodule

// File: tb/tb_lap_referee.sv
// Self-checking bench for lap_referee: directed race scenarios plus random
// driving, compared every cycle against an integer-level race model.
module tb_lap_referee;

   localparam int NUM_LAPS = 2;
   localparam int NUM_CP   = 3;
   localparam int TICK_DIV = 4;
   localparam int GRACE    = 5;
   localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd3, S_RACE = 3'd4, S_PAUSE = 3'd5;

   logic        clk, rst;
   logic [2:0]  state;
   logic [9:0]  p1_x, p1_y, p2_x, p2_y;
   logic [2:0]  p1_lap, p2_lap;
   logic [1:0]  p1_next_cp, p2_next_cp, p1_flag_order, p2_flag_order, winner;
   logic [15:0] p1_time, p2_time, race_time;
   logic        is_game_end;

   lap_referee #(
      .NUM_LAPS(NUM_LAPS), .NUM_CP(NUM_CP),
      .CP_X({10'd0, 10'd100, 10'd100, 10'd15}),
      .CP_Y({10'd0, 10'd200, 10'd125, 10'd125}),
      .CP_HALF(10'd2), .TICK_DIV(TICK_DIV), .GRACE_TICKS(GRACE)
   ) dut (
      .clk(clk), .rst(rst), .state(state),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .p1_lap(p1_lap), .p2_lap(p2_lap),
      .p1_next_cp(p1_next_cp), .p2_next_cp(p2_next_cp),
      .p1_flag_order(p1_flag_order), .p2_flag_order(p2_flag_order),
      .p1_time(p1_time), .p2_time(p2_time), .race_time(race_time),
      .winner(winner), .is_game_end(is_game_end)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   int cpx[3] = '{15, 100, 100};
   int cpy[3] = '{125, 125, 200};

   // Reference model state (plain integers)
   int m_sub, m_time, m_grace, m_winner;
   int m_lap[2], m_next[2], m_place[2], m_ptime[2];
   bit m_end;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic m_clear();
      m_sub = 0; m_time = 0; m_grace = 0; m_winner = 0; m_end = 0;
      for (int p = 0; p < 2; p++) begin
         m_lap[p] = 0; m_next[p] = 1; m_place[p] = 0; m_ptime[p] = 0;
      end
   endtask

   function automatic bit m_in(input int x, input int y, input int cp);
      int dx, dy;
      dx = x - cpx[cp]; if (dx < 0) dx = -dx;
      dy = y - cpy[cp]; if (dy < 0) dy = -dy;
      return (dx <= 2) && (dy <= 2);
   endfunction

   task automatic m_step(input logic [2:0] st, input int x1, input int y1, input int x2, input int y2);
      int xs[2], ys[2];
      bit tick, one_fin;
      bit done[2];
      int old_time;
      xs[0] = x1; ys[0] = y1; xs[1] = x2; ys[1] = y2;
      if (st == S_IDLE) begin
         m_clear();
         return;
      end
      if (st != S_RACE || m_end) return;
      tick  = (m_sub == TICK_DIV - 1);
      m_sub = (m_sub + 1) % TICK_DIV;
      old_time = m_time;
      if (tick && m_time < 65535) m_time++;
      one_fin = (m_place[0] != 0) != (m_place[1] != 0);
      for (int p = 0; p < 2; p++) begin
         done[p] = 0;
         if (m_place[p] == 0 && m_in(xs[p], ys[p], m_next[p])) begin
            if (m_next[p] == 0) begin
               m_lap[p]++;
               m_next[p] = 1;
               done[p] = (m_lap[p] == NUM_LAPS);
            end else begin
               m_next[p] = (m_next[p] + 1) % NUM_CP;
            end
         end
      end
      if (done[0] && done[1]) begin
         m_place[0] = 1; m_place[1] = 1;
         m_ptime[0] = old_time; m_ptime[1] = old_time;
         m_winner = 3; m_end = 1;
      end else if (done[0] || done[1]) begin
         for (int p = 0; p < 2; p++) begin
            if (done[p]) begin
               m_ptime[p] = old_time;
               if (m_place[1-p] != 0) begin
                  m_place[p] = 2; m_end = 1;
               end else begin
                  m_place[p] = 1; m_winner = p + 1;
               end
            end
         end
      end else if (one_fin && tick) begin
         m_grace++;
         if (m_grace == GRACE) begin
            for (int p = 0; p < 2; p++) begin
               if (m_place[p] == 0) begin
                  m_place[p] = 2; m_ptime[p] = 65535; m_end = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("p1_lap",  32'(p1_lap),        32'(m_lap[0]));
      chk("p2_lap",  32'(p2_lap),        32'(m_lap[1]));
      chk("p1_next", 32'(p1_next_cp),    32'(m_next[0]));
      chk("p2_next", 32'(p2_next_cp),    32'(m_next[1]));
      chk("p1_place",32'(p1_flag_order), 32'(m_place[0]));
      chk("p2_place",32'(p2_flag_order), 32'(m_place[1]));
      chk("p1_time", 32'(p1_time),       32'(m_ptime[0]));
      chk("p2_time", 32'(p2_time),       32'(m_ptime[1]));
      chk("race_time", 32'(race_time),   32'(m_time));
      chk("winner",  32'(winner),        32'(m_winner));
      chk("game_end",32'(is_game_end),   32'(m_end));
   endtask

   task automatic cyc(input logic [2:0] st, input int x1, input int y1, input int x2, input int y2);
      state = st;
      p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
      @(posedge clk);
      m_step(st, x1, y1, x2, y2);
      #1;
      check_all();
   endtask

   task automatic park(input int n);
      for (int i = 0; i < n; i++) cyc(S_RACE, 50, 50, 50, 50);
   endtask

   task automatic run_to_time(input int t);
      int guard;
      guard = 0;
      while (m_time != t && guard < 1000) begin
         park(1);
         guard++;
      end
      if (guard >= 1000) begin
         n_checks++;
         $error("FAIL wait_bound: observed %0d expected %0d", m_time, t);
      end
   endtask

   initial begin
      int r, st, xs[2], ys[2];
      rst = 1'b0; state = S_RACE;
      p1_x = 10'd50; p1_y = 10'd50; p2_x = 10'd50; p2_y = 10'd50;
      m_clear();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_next_const", 32'(p1_next_cp), 32'd1);
      #2 rst = 1'b1;
      #1 check_all();

      // Timer: 20 racing cycles, pause, partial-tick resume
      park(20);
      chk("t1_time5", 32'(race_time), 32'd5);
      for (int i = 0; i < 10; i++) cyc(S_PAUSE, 50, 50, 50, 50);
      chk("t1_pause", 32'(race_time), 32'd5);
      park(2);
      chk("t1_resume2", 32'(race_time), 32'd5);
      park(2);
      chk("t1_resume4", 32'(race_time), 32'd6);

      // Lap counting
      cyc(S_RACE, 100, 125, 50, 50);
      chk("t2_cp1", 32'(p1_next_cp), 32'd2);
      cyc(S_RACE, 100, 200, 50, 50);
      chk("t2_cp2", 32'(p1_next_cp), 32'd0);
      cyc(S_RACE, 15, 125, 50, 50);
      chk("t2_lap1", 32'(p1_lap), 32'd1);
      for (int i = 0; i < 10; i++) cyc(S_RACE, 15, 125, 50, 50);
      chk("t2_dwell", 32'(p1_lap), 32'd1);

      // Out-of-order and countdown, then box edges
      cyc(S_RACE, 100, 200, 50, 50);
      chk("t3_skip", 32'(p1_next_cp), 32'd1);
      cyc(S_CD, 100, 125, 50, 50);
      chk("t3_countdown", 32'(p1_next_cp), 32'd1);
      cyc(S_RACE, 103, 125, 50, 50);
      chk("t2_edge_out", 32'(p1_next_cp), 32'd1);
      cyc(S_RACE, 102, 127, 50, 50);
      chk("t2_edge_in", 32'(p1_next_cp), 32'd2);

      // Asynchronous reset between edges
      #2 rst = 1'b0;
      #1 m_clear();
      check_all();
      chk("t6_async_lap", 32'(p1_lap), 32'd0);
      #1 rst = 1'b1;
      #1 check_all();

      // Normal finish: P1 at 30, P2 at 33
      for (int k = 0; k < 5; k++) cyc(S_RACE, cpx[(k+1)%3], cpy[(k+1)%3], cpx[(k+1)%3], cpy[(k+1)%3]);
      run_to_time(30);
      cyc(S_RACE, 15, 125, 50, 50);
      chk("t4_p1_place", 32'(p1_flag_order), 32'd1);
      chk("t4_p1_time",  32'(p1_time), 32'd30);
      chk("t4_winner",   32'(winner), 32'd1);
      run_to_time(33);
      cyc(S_RACE, 50, 50, 15, 125);
      chk("t4_p2_place", 32'(p2_flag_order), 32'd2);
      chk("t4_p2_time",  32'(p2_time), 32'd33);
      chk("t4_end",      32'(is_game_end), 32'd1);
      cyc(S_IDLE, 50, 50, 50, 50);
      chk("t4_idle_next", 32'(p2_next_cp), 32'd1);

      // Grace expiry
      for (int k = 0; k < 5; k++) cyc(S_RACE, cpx[(k+1)%3], cpy[(k+1)%3], 50, 50);
      cyc(S_RACE, 15, 125, 50, 50);
      park(20);
      chk("t5_grace_place", 32'(p2_flag_order), 32'd2);
      chk("t5_grace_time",  32'(p2_time), 32'hFFFF);
      chk("t5_grace_end",   32'(is_game_end), 32'd1);
      cyc(S_IDLE, 50, 50, 50, 50);

      // Tie
      for (int k = 0; k < 6; k++) cyc(S_RACE, cpx[(k+1)%3], cpy[(k+1)%3], cpx[(k+1)%3], cpy[(k+1)%3]);
      chk("t5_tie_winner", 32'(winner), 32'd3);
      chk("t5_tie_p1", 32'(p1_flag_order), 32'd1);
      chk("t5_tie_p2", 32'(p2_flag_order), 32'd1);
      chk("t5_tie_end", 32'(is_game_end), 32'd1);
      cyc(S_IDLE, 50, 50, 50, 50);

      // Random driving checked against the model
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (m_end && r < 10)  st = 0;
         else if (r < 82)      st = 4;
         else if (r < 83)      st = 0;
         else                  st = int'($urandom_range(1, 7));
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 9) < 7) begin
               xs[p] = cpx[m_next[p]] + int'($urandom_range(0, 6)) - 3;
               ys[p] = cpy[m_next[p]] + int'($urandom_range(0, 6)) - 3;
            end else begin
               xs[p] = int'($urandom_range(0, 1023));
               ys[p] = int'($urandom_range(0, 1023));
            end
         end
         cyc(3'(st), xs[0], ys[0], xs[1], ys[1]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
